// File: rtl/hamming_top_module.sv
// ============================================================================
// Module      : hamming_top_module
// Description : Serial Hamming(7,4) codeword receiver with syndrome-based
//               error detection (detect only, no correction).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_top_module (
  input  logic        clock,
  input  logic        reset,
  input  logic        dataIncoming,
  input  logic        dataIn,
  input  logic [31:0] clockCount,
  output logic [6:0]  currentData,
  output logic [2:0]  parity,
  output logic        errorFound,
  output logic        done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RECEIVE = 2'd1;
  localparam logic [1:0] S_CHECK   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [31:0] C_CODE_LEN = 32'd7;

  logic [1:0] r_state;
  logic [6:0] r_data;
  logic [2:0] r_parity;
  logic       r_error;
  logic       r_done;

  logic       w_index_ok;
  logic       w_bit_valid;
  logic [6:0] w_bit_mask;
  logic [6:0] w_bit_value;
  logic [2:0] w_syndrome;

  // Out-of-range indices produce an all-zero mask, so the bit is simply dropped.
  assign w_index_ok  = (clockCount < C_CODE_LEN);
  assign w_bit_valid = dataIncoming & w_index_ok;

  always_comb begin
    w_bit_mask = 7'd0;
    if (w_index_ok) begin
      w_bit_mask = 7'b000_0001 << clockCount[2:0];
    end
  end

  assign w_bit_value = {7{dataIn}} & w_bit_mask;

  assign w_syndrome[0] = r_data[0] ^ r_data[2] ^ r_data[4] ^ r_data[5];
  assign w_syndrome[1] = r_data[1] ^ r_data[2] ^ r_data[5] ^ r_data[6];
  assign w_syndrome[2] = r_data[3] ^ r_data[4] ^ r_data[5] ^ r_data[6];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_data   <= 7'd0;
      r_parity <= 3'd0;
      r_error  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // A new frame starts only on a bit that is actually captured.
          if (w_bit_valid) begin
            r_data   <= w_bit_value;
            r_parity <= 3'd0;
            r_error  <= 1'b0;
            r_done   <= 1'b0;
            r_state  <= S_RECEIVE;
          end
        end
        S_RECEIVE: begin
          if (dataIncoming) begin
            r_data <= (r_data & ~w_bit_mask) | w_bit_value;
          end else begin
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_parity <= w_syndrome;
          r_error  <= |w_syndrome;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign currentData = r_data;
  assign parity      = r_parity;
  assign errorFound  = r_error;
  assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_hamming_top_module.sv
// ============================================================================
// Module      : tb_hamming_top_module
// Description : Randomized self-checking bench for hamming_top_module against
//               a frame-level reference model using parity-check columns.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hamming_top_module;

  logic        clock = 1'b0;
  logic        reset;
  logic        dataIncoming;
  logic        dataIn;
  logic [31:0] clockCount;
  logic [6:0]  currentData;
  logic [2:0]  parity;
  logic        errorFound;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [6:0] m_data;
  logic [2:0] m_par;
  logic       m_err;
  logic       m_done;
  bit         in_frame;

  hamming_top_module dut (
    .clock        (clock),
    .reset        (reset),
    .dataIncoming (dataIncoming),
    .dataIn       (dataIn),
    .clockCount   (clockCount),
    .currentData  (currentData),
    .parity       (parity),
    .errorFound   (errorFound),
    .done         (done)
  );

  always #5 clock = ~clock;

  function automatic logic [2:0] h_col(input int i);
    case (i)
      0: h_col = 3'b001;
      1: h_col = 3'b010;
      2: h_col = 3'b011;
      3: h_col = 3'b100;
      4: h_col = 3'b101;
      5: h_col = 3'b111;
      default: h_col = 3'b110;
    endcase
  endfunction

  // Syndrome is the XOR of the H columns of every set bit.
  function automatic logic [2:0] syndrome_of(input logic [6:0] w);
    logic [2:0] s;
    s = 3'b000;
    for (int i = 0; i < 7; i++) begin
      if (w[i]) s = s ^ h_col(i);
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_data"}, {25'd0, currentData}, {25'd0, m_data});
    check({tag, "_par"},  {29'd0, parity},      {29'd0, m_par});
    check({tag, "_err"},  {31'd0, errorFound},  {31'd0, m_err});
    check({tag, "_done"}, {31'd0, done},        {31'd0, m_done});
  endtask

  task automatic present(input int idx, input logic b);
    dataIncoming = 1'b1;
    clockCount   = idx;
    dataIn       = b;
    tick();
    if (idx >= 0 && idx < 7) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        m_data   = 7'd0;
        m_par    = 3'd0;
        m_err    = 1'b0;
        m_done   = 1'b0;
      end
      m_data[idx] = b;
    end
    check_outputs("bit");
  endtask

  task automatic finish_frame;
    dataIncoming = 1'b0;
    dataIn       = 1'($urandom);
    clockCount   = $urandom_range(0, 15);
    tick();
    check_outputs("drop");
    if (in_frame) begin
      tick();
      m_par    = syndrome_of(m_data);
      m_err    = |m_par;
      m_done   = 1'b1;
      in_frame = 1'b0;
      check_outputs("result");
    end
  endtask

  task automatic idle(input int n);
    dataIncoming = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      check_outputs("idle");
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    m_data   = 7'd0;
    m_par    = 3'd0;
    m_err    = 1'b0;
    m_done   = 1'b0;
    in_frame = 1'b0;
    check_outputs("reset");
  endtask

  task automatic send_word(input logic [6:0] w);
    for (int i = 0; i < 7; i++) present(i, w[i]);
    finish_frame();
  endtask

  initial begin
    reset        = 1'b1;
    dataIncoming = 1'b0;
    dataIn       = 1'b0;
    clockCount   = 32'd0;
    m_data = 7'd0; m_par = 3'd0; m_err = 1'b0; m_done = 1'b0; in_frame = 1'b0;
    tick();
    do_reset();

    // Nominal clean codeword, outputs hold afterwards
    send_word(7'b1010100);
    check("tp_clean_par", {29'd0, parity}, 32'h0);
    check("tp_clean_done", {31'd0, done}, 32'h1);
    idle(2);

    send_word(7'b1010101);
    check("tp_d0_par", {29'd0, parity}, 32'h1);
    check("tp_d0_err", {31'd0, errorFound}, 32'h1);

    send_word(7'b1110100);
    check("tp_d5_par", {29'd0, parity}, 32'h7);

    // Back-to-back frames
    send_word(7'b0000000);
    send_word(7'b1111111);
    check("tp_ones_err", {31'd0, errorFound}, 32'h0);

    // Reset aborts a frame after three bits
    present(0, 1'b1);
    present(1, 1'b0);
    present(2, 1'b1);
    do_reset();
    send_word(7'b1010100);
    check("tp_after_rst_err", {31'd0, errorFound}, 32'h0);

    // Out-of-range index mid-frame is ignored
    present(0, 1'b0);
    present(1, 1'b0);
    present(9, 1'b1);
    present(2, 1'b1);
    present(3, 1'b0);
    present(4, 1'b1);
    present(5, 1'b0);
    present(6, 1'b1);
    finish_frame();
    check("tp_idx9_data", {25'd0, currentData}, 32'h54);

    // Randomized frames: short/long, repeats, invalid indices, gaps, resets
    for (int f = 0; f < 60; f++) begin
      int len;
      len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) begin
        int idx;
        case ($urandom_range(0, 9))
          0:       idx = $urandom_range(7, 40);
          1:       idx = -1;
          default: idx = $urandom_range(0, 6);
        endcase
        present(idx, 1'($urandom));
        if ($urandom_range(0, 49) == 0) do_reset();
      end
      finish_frame();
      idle($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
